// File: rtl/motor_cmd_arbiter_pkg.sv
// Shared command codes, H-bridge patterns and FSM states for the motor command path.
package motor_cmd_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // {L_in1, L_in2, R_in1, R_in2}
  localparam logic [3:0] MOTOR_STOP  = 4'b0000;
  localparam logic [3:0] MOTOR_FWD   = 4'b1010;
  localparam logic [3:0] MOTOR_BACK  = 4'b0101;
  localparam logic [3:0] MOTOR_LEFT  = 4'b0110;
  localparam logic [3:0] MOTOR_RIGHT = 4'b1001;

  function automatic cmd_e map_cmd(input logic [2:0] raw);
    case (raw)
      3'd1:    map_cmd = CMD_FWD;
      3'd2:    map_cmd = CMD_BACK;
      3'd3:    map_cmd = CMD_LEFT;
      3'd4:    map_cmd = CMD_RIGHT;
      default: map_cmd = CMD_STOP;
    endcase
  endfunction

  function automatic logic [3:0] motor_code(input cmd_e c);
    case (c)
      CMD_FWD:   motor_code = MOTOR_FWD;
      CMD_BACK:  motor_code = MOTOR_BACK;
      CMD_LEFT:  motor_code = MOTOR_LEFT;
      CMD_RIGHT: motor_code = MOTOR_RIGHT;
      default:   motor_code = MOTOR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/motor_soft_start.sv
// Duty ramp (25 % steps up to 100 %) and PWM gate for the motor bits; restarts whenever run drops.
module motor_soft_start #(
  parameter int RAMP_STEP_CYC = 500_000,
  parameter int PWM_PERIOD    = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic pwm_on
);

  localparam int SW      = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam int PW      = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int QUARTER = PWM_PERIOD / 4;

  logic [SW-1:0] step_cnt_reg;
  logic [PW-1:0] pwm_cnt_reg;
  logic [2:0]    duty_reg;     // quarters of the period, 1..4
  logic [31:0]   thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      duty_reg     <= 3'd1;
    end else if (!run) begin
      step_cnt_reg <= '0;
      pwm_cnt_reg  <= '0;
      duty_reg     <= 3'd1;
    end else begin
      pwm_cnt_reg <= (pwm_cnt_reg == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_reg + 1'b1;
      if (duty_reg != 3'd4) begin
        if (step_cnt_reg == SW'(RAMP_STEP_CYC - 1)) begin
          step_cnt_reg <= '0;
          duty_reg     <= duty_reg + 3'd1;
        end else begin
          step_cnt_reg <= step_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign thresh = 32'(duty_reg) * 32'(QUARTER);
  // Full duty bypasses the compare so a period not divisible by 4 is still fully on.
  assign pwm_on = run && ((duty_reg == 3'd4) || (32'(pwm_cnt_reg) < thresh));

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Remote/autonomous command arbiter with brake dead-time sequencing to the H-bridge.
// Optional soft-start PWM ramp enabled by defining SOFT_START_EN.
module motor_cmd_arbiter
  import motor_cmd_arbiter_pkg::*;
#(
  parameter int DEAD_CYC      = 50_000,
  parameter int HOLD_CYC      = 25_000_000,
  parameter int RAMP_STEP_CYC = 500_000,
  parameter int PWM_PERIOD    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       remote_valid,
  input  logic [2:0] remote_cmd,
  input  logic       auto_en,
  input  logic [2:0] auto_cmd,
  output logic [3:0] motor,
  output logic       owner,
  output logic       busy
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  if (DEAD_CYC < 1 || HOLD_CYC < 1 || RAMP_STEP_CYC < 1 || PWM_PERIOD < 4) begin : g_bad_cfg
    $fatal(1, "motor_cmd_arbiter: invalid timing parameters");
  end

  logic          owner_reg;
  logic [HW-1:0] hold_cnt_reg;
  cmd_e          req_reg;

  // A strobe always wins, including on the cycle ownership would otherwise expire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg    <= 1'b0;
      hold_cnt_reg <= '0;
      req_reg      <= CMD_STOP;
    end else if (remote_valid) begin
      owner_reg    <= 1'b1;
      hold_cnt_reg <= '0;
      req_reg      <= map_cmd(remote_cmd);
    end else if (owner_reg) begin
      if (hold_cnt_reg == HW'(HOLD_CYC - 1)) begin
        owner_reg    <= 1'b0;
        hold_cnt_reg <= '0;
      end else begin
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
      end
    end else begin
      req_reg <= auto_en ? map_cmd(auto_cmd) : CMD_STOP;
    end
  end

  state_e        state_reg, state_next;
  cmd_e          cmd_reg, cmd_next;      // running code in RUN, pending code in DEAD
  logic [DW-1:0] dead_cnt_reg, dead_cnt_next;
  logic [3:0]    motor_reg, motor_next;
  logic          busy_reg, busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= CMD_STOP;
      dead_cnt_reg <= '0;
      motor_reg    <= MOTOR_STOP;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      dead_cnt_reg <= dead_cnt_next;
      motor_reg    <= motor_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    dead_cnt_next = dead_cnt_reg;
    motor_next    = motor_reg;
    busy_next     = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        motor_next = MOTOR_STOP;
        busy_next  = 1'b0;
        if (req_reg != CMD_STOP) begin
          state_next = ST_RUN;
          cmd_next   = req_reg;
          motor_next = motor_code(req_reg);
        end
      end
      ST_RUN: begin
        if (req_reg == CMD_STOP) begin
          state_next = ST_IDLE;
          cmd_next   = CMD_STOP;
          motor_next = MOTOR_STOP;
        end else if (req_reg != cmd_reg) begin
          state_next    = ST_DEAD;
          cmd_next      = req_reg;
          dead_cnt_next = '0;
          motor_next    = MOTOR_STOP;
          busy_next     = 1'b1;
        end
      end
      ST_DEAD: begin
        motor_next = MOTOR_STOP;
        // The brake always runs its full length, even if the request returns to the old code.
        if (req_reg == CMD_STOP) begin
          state_next    = ST_IDLE;
          cmd_next      = CMD_STOP;
          dead_cnt_next = '0;
          busy_next     = 1'b0;
        end else if (dead_cnt_reg == DW'(DEAD_CYC - 1)) begin
          state_next    = ST_RUN;
          cmd_next      = req_reg;
          dead_cnt_next = '0;
          motor_next    = motor_code(req_reg);
          busy_next     = 1'b0;
        end else begin
          cmd_next      = req_reg;
          dead_cnt_next = dead_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        cmd_next      = CMD_STOP;
        dead_cnt_next = '0;
        motor_next    = MOTOR_STOP;
        busy_next     = 1'b0;
      end
    endcase
  end

`ifdef SOFT_START_EN
  logic pwm_on;

  motor_soft_start #(
    .RAMP_STEP_CYC (RAMP_STEP_CYC),
    .PWM_PERIOD    (PWM_PERIOD)
  ) u_soft_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_reg == ST_RUN),
    .pwm_on (pwm_on)
  );

  assign motor = motor_reg & {4{pwm_on}};
`else
  assign motor = motor_reg;
`endif

  assign owner = owner_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Self-checking bench for motor_cmd_arbiter (default build): directed scenarios then random traffic
// against a cycle-level behavioural model.
module tb_motor_cmd_arbiter;

  localparam int DEAD = 4;
  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       remote_valid;
  logic [2:0] remote_cmd;
  logic       auto_en;
  logic [2:0] auto_cmd;
  logic [3:0] motor;
  logic       owner;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  motor_cmd_arbiter #(
    .DEAD_CYC      (DEAD),
    .HOLD_CYC      (HOLD),
    .RAMP_STEP_CYC (8),
    .PWM_PERIOD    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .remote_valid (remote_valid),
    .remote_cmd   (remote_cmd),
    .auto_en      (auto_en),
    .auto_cmd     (auto_cmd),
    .motor        (motor),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Model: remote ownership as "cycles since last strobe", the drive as a direction plus
  // a remaining-brake count; req_m is the arbitrated request seen by the drive stage.
  int age_m, rcmd_m, req_m, dir_m, dead_left_m;

  function automatic int norm(input int c);
    return (c > 4) ? 0 : c;
  endfunction

  function automatic logic [3:0] pattern(input int d);
    case (d)
      1:       return 4'b1010;
      2:       return 4'b0101;
      3:       return 4'b0110;
      4:       return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    age_m = HOLD; rcmd_m = 0; req_m = 0; dir_m = 0; dead_left_m = 0;
  endtask

  task automatic model_edge();
    bit was_owner;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (dead_left_m > 0) begin
      if (req_m == 0) begin
        dir_m = 0; dead_left_m = 0;
      end else begin
        dead_left_m--;
        if (dead_left_m == 0) dir_m = req_m;
      end
    end else if (req_m == 0) begin
      dir_m = 0;
    end else if (dir_m == 0) begin
      dir_m = req_m;
    end else if (req_m != dir_m) begin
      dead_left_m = DEAD;
    end
    was_owner = (age_m < HOLD);
    if (remote_valid) begin
      age_m = 0; rcmd_m = norm(int'(remote_cmd)); req_m = rcmd_m;
    end else if (was_owner) begin
      age_m++; req_m = rcmd_m;
    end else begin
      req_m = auto_en ? norm(int'(auto_cmd)) : 0;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check({tag, "_motor"}, motor, (dead_left_m > 0) ? 4'b0000 : pattern(dir_m));
    check({tag, "_owner"}, {3'b000, owner}, {3'b000, age_m < HOLD});
    check({tag, "_busy"},  {3'b000, busy},  {3'b000, dead_left_m > 0});
  endtask

  task automatic strobe(input logic [2:0] c, input string tag);
    remote_valid = 1'b1;
    remote_cmd   = c;
    tick(tag);
    remote_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; remote_valid = 1'b0; remote_cmd = 3'd0; auto_en = 1'b0; auto_cmd = 3'd0;
    model_reset();

    // Reset held while the remote keeps strobing fwd
    remote_valid = 1'b1; remote_cmd = 3'd1;
    for (int i = 0; i < 4; i++) tick("reset");
    check("reset_motor_const", motor, 4'b0000);
    remote_valid = 1'b0;
    rst_n = 1'b1;
    tick("idle");
    tick("idle");

    // Fwd from IDLE, visible two edges after the strobe
    strobe(3'd1, "fwd_e1");
    check("fwd_one_edge", motor, 4'b0000);
    tick("fwd_e2");
    check("fwd_two_edge", motor, 4'b1010);

    // Fwd -> back with full brake
    strobe(3'd2, "back");
    tick("back");
    check("back_busy", {3'b000, busy}, 4'b0001);
    for (int i = 0; i < 5; i++) tick("back_dead");
    check("back_motor", motor, 4'b0101);

    // Stop during DEAD aborts to IDLE, then fwd applies without brake
    strobe(3'd1, "to_fwd");
    tick("to_fwd");
    tick("to_fwd");
    strobe(3'd0, "dead_stop");
    tick("dead_stop");
    check("dead_stop_busy", {3'b000, busy}, 4'b0000);
    strobe(3'd1, "refwd");
    tick("refwd");
    check("refwd_motor", motor, 4'b1010);

    // Remote silence hands back to autonomous left
    auto_en = 1'b1; auto_cmd = 3'd3;
    strobe(3'd1, "hold");
    for (int i = 0; i < 30; i++) tick("hold");
    check("auto_left", motor, 4'b0110);
    check("auto_owner", {3'b000, owner}, 4'b0000);
    auto_en = 1'b0;
    tick("auto_off");
    tick("auto_off");
    check("auto_off_motor", motor, 4'b0000);

    // Unused code 6 behaves as stop
    strobe(3'd1, "pre6");
    tick("pre6");
    tick("pre6");
    strobe(3'd6, "code6");
    tick("code6");
    check("code6_motor", motor, 4'b0000);

    // Asynchronous reset while running
    strobe(3'd4, "right");
    tick("right");
    tick("right");
    rst_n = 1'b0;
    #1;
    check("async_motor", motor, 4'b0000);
    check("async_owner", {3'b000, owner}, 4'b0000);
    tick("async");
    rst_n = 1'b1;
    tick("async_rel");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      remote_valid = ($urandom_range(0, 9) == 0);
      remote_cmd   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 7) == 0) auto_cmd = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 299) != 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
